// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: per-stage enables/flushes for load-use, mispredict and dmem waits.
// Optional perf counters (stall_cycles, flush_events) are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_unit #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        rs1_used_id,
  input  logic        rs2_used_id,
  input  logic [4:0]  rd_ex,
  input  logic        mem_read_ex,
  input  logic        wb_reg_file_ex,
  input  logic        mispredict_ex,
  input  logic        dmem_req_mem,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_en,
  output logic        id_ex_flush,
  output logic        ex_mem_en,
  output logic        mem_wb_bubble,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_t;
  typedef enum logic [1:0] {M_NORM, M_LU, M_REDIR, M_FREEZE} mode_t;

  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [9:0] TMO_CNT      = 10'(MEM_TIMEOUT - 1);

  state_t     state, state_nxt;
  mode_t      mode;
  logic [3:0] flush_cnt, flush_cnt_nxt;
  logic [9:0] wait_cnt, wait_cnt_nxt;
  logic       timeout_set;
  logic       lu, ms;

  assign lu = mem_read_ex & wb_reg_file_ex & (rd_ex != 5'd0) &
              ((rs1_used_id & (rs1_id == rd_ex)) | (rs2_used_id & (rs2_id == rd_ex)));
  assign ms = dmem_req_mem & ~dmem_ready;

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    wait_cnt_nxt  = wait_cnt;
    timeout_set   = 1'b0;
    mode          = M_NORM;
    if (ms) begin
      mode = M_FREEZE;
      case (state)
        RUN: begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 10'd1;
        end
        MEM_WAIT: begin
          if (wait_cnt != 10'd1023) wait_cnt_nxt = wait_cnt + 10'd1;
          if (wait_cnt == TMO_CNT) timeout_set = 1'b1;
        end
        default: ;  // REDIRECT holds its flush count while frozen
      endcase
    end else if (mispredict_ex) begin
      mode = M_REDIR;
      if (FLUSH_CYCLES > 1) begin
        state_nxt     = REDIRECT;
        flush_cnt_nxt = FLUSH_RELOAD;
      end else begin
        state_nxt = RUN;
      end
    end else if (state == REDIRECT) begin
      // lu is ignored here: the ID instruction is being flushed anyway
      mode          = M_REDIR;
      flush_cnt_nxt = flush_cnt - 4'd1;
      if (flush_cnt == 4'd1) state_nxt = RUN;
    end else begin
      state_nxt = RUN;
      mode      = lu ? M_LU : M_NORM;
    end
    if (!ms && state == MEM_WAIT) wait_cnt_nxt = 10'd0;
  end

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_bubble = 1'b0;
    case (mode)
      M_FREEZE: begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b1;
      end
      M_REDIR: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      M_LU: begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      flush_cnt   <= 4'd0;
      wait_cnt    <= 10'd0;
      mem_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      if (timeout_set) mem_timeout <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
    end else begin
      if (!pc_en) stall_cycles <= stall_cycles + 32'd1;
      if (mispredict_ex && !ms) flush_events <= flush_events + 32'd1;
    end
  end
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Pipeline hazard controller. Produces the per-stage enable and flush controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
- Detects load-use hazards, branch/jump mispredicts and data-memory wait states, and sequences multi-cycle flush and stall windows with a small FSM.
- Sits beside the decode and execute stages. Its id_ex_en and id_ex_flush outputs drive the ID/EX register directly; in that register, flush has priority over enable.

Parameters:
- FLUSH_CYCLES, 1: number of consecutive cycles IF/ID and ID/EX are flushed per mispredict (1 to 15).
- MEM_TIMEOUT, 64: MEM_WAIT cycle count at which mem_timeout sets (2 to 1023).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rs1_id  in  5  ID-stage source register 1
- rs2_id  in  5  ID-stage source register 2
- rs1_used_id  in  1  ID instruction reads rs1
- rs2_used_id  in  1  ID instruction reads rs2
- rd_ex  in  5  EX-stage destination register
- mem_read_ex  in  1  EX instruction is a load
- wb_reg_file_ex  in  1  EX instruction writes the register file
- mispredict_ex  in  1  EX branch/jump resolved against prediction (redirect this cycle)
- dmem_req_mem  in  1  MEM stage has an active data-memory request
- dmem_ready  in  1  data memory completes the request this cycle
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID enable
- if_id_flush  out  1  IF/ID flush
- id_ex_en  out  1  ID/EX enable
- id_ex_flush  out  1  ID/EX flush (bubble insert)
- ex_mem_en  out  1  EX/MEM enable
- mem_wb_bubble  out  1  MEM/WB loads a bubble
- mem_timeout  out  1  sticky: memory wait exceeded MEM_TIMEOUT
- stall_cycles  out  32  performance counter (optional feature)
- flush_events  out  32  performance counter (optional feature)

Behaviour:
- Terms:
  - lu = mem_read_ex & wb_reg_file_ex & (rd_ex!=0) & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex)).
  - ms = dmem_req_mem & ~dmem_ready.
- All control outputs are combinational from the current state and inputs, so a stall takes effect in the same cycle as its cause.
- Registered state: fsm (RUN, MEM_WAIT, REDIRECT), flush_cnt[3:0], wait_cnt[9:0], mem_timeout.
- Reset: fsm=RUN, flush_cnt=0, wait_cnt=0, mem_timeout=0, counters=0. Reset mid-window aborts it; the next cycle is plain RUN.
- Output rule sets:
  - FREEZE: pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_bubble=1, flushes=0.
  - REDIR: pc_en=if_id_en=id_ex_en=ex_mem_en=1, if_id_flush=id_ex_flush=1, mem_wb_bubble=0.
  - LU: pc_en=if_id_en=0, id_ex_flush=1, id_ex_en=ex_mem_en=1, if_id_flush=0, mem_wb_bubble=0.
  - NORM: all enables 1, flushes 0, mem_wb_bubble=0.
- Priority in every state: ms > mispredict_ex > REDIRECT window > lu > NORM.
- RUN:
  - ms: apply FREEZE, go to MEM_WAIT, wait_cnt<=1.
  - else mispredict_ex: apply REDIR. If FLUSH_CYCLES>1, flush_cnt<=FLUSH_CYCLES-1 and go to REDIRECT; else stay in RUN.
  - else lu: apply LU.
  - else: apply NORM.
- MEM_WAIT:
  - ms: apply FREEZE; wait_cnt increments, saturating at 1023. When wait_cnt==MEM_TIMEOUT-1 while ms, mem_timeout<=1 (sticky until rst).
  - ~ms: evaluate exactly as RUN for outputs and next state; wait_cnt<=0.
- REDIRECT:
  - ms: apply FREEZE; flush_cnt held; stay in REDIRECT.
  - else mispredict_ex: apply REDIR; reload flush_cnt<=FLUSH_CYCLES-1.
  - else: apply REDIR; flush_cnt decrements; when flush_cnt==1, go to RUN.
  - lu is ignored in REDIRECT because the ID stage is being flushed.
- mem_timeout does not alter control behaviour; it is a status flag only.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments on every cycle with pc_en==0.
  - flush_events increments on every cycle with mispredict_ex accepted (not masked by ms).
  - Both wrap modulo 2^32 and clear on rst.
- Not defined: stall_cycles and flush_events are constant 0 and no counter registers exist.

Test Plan:
- Load-use: mem_read_ex=1, wb_reg_file_ex=1, rd_ex=5, rs1_id=5, rs1_used_id=1 -> same cycle pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1. With rd_ex=0 -> NORM.
- Mispredict with FLUSH_CYCLES=3: mispredict_ex pulsed 1 cycle -> if_id_flush=id_ex_flush=1 for exactly 3 cycles, pc_en=1 throughout, then NORM.
- Memory wait: dmem_req_mem=1, dmem_ready=0 for 4 cycles then 1 -> 4 FREEZE cycles (mem_wb_bubble=1), NORM on the ready cycle, mem_timeout stays 0.
- Timeout with MEM_TIMEOUT=8: hold ms for 10 cycles -> mem_timeout rises after the 8th wait cycle and stays 1 after ready, until rst.
- Simultaneous events: ms and mispredict_ex together -> FREEZE, no flush. After ready with mispredict_ex still 1 -> REDIR. lu and mispredict_ex together -> REDIR.
- Async rst asserted mid-REDIRECT -> outputs immediately NORM; no residual flush after release. With HAZARD_PERF_CNT_EN, the first load-use test gives stall_cycles=1.
